// File: rtl/dkongjr_obj_arb_if.sv
// CPU-side bus of the object RAM arbiter.
// The CPU (master) drives address, write data and the active-low strobes.
// The arbiter (slave) returns read data and the active-low wait line.
interface dkongjr_obj_arb_if;
    logic [9:0] I_CPU_AB;
    logic [7:0] I_CPU_DB;
    logic       I_CPU_WRn;
    logic       I_CPU_RDn;
    logic [7:0] O_CPU_DB;
    logic       O_CPU_WAITn;

    modport master (
        output I_CPU_AB, I_CPU_DB, I_CPU_WRn, I_CPU_RDn,
        input  O_CPU_DB, O_CPU_WAITn
    );

    modport slave (
        input  I_CPU_AB, I_CPU_DB, I_CPU_WRn, I_CPU_RDn,
        output O_CPU_DB, O_CPU_WAITn
    );
endinterface

// File: rtl/dkongjr_obj_arb.sv
// Object RAM arbiter / sequencer for the sprite line engine.
// Shares the single 1K x 8 object RAM port between the line scanner (which
// owns the RAM whenever I_H_CNT[9] is low), a CPU port with wait states, and
// a once-per-frame block-copy DMA from work RAM.
// Optional feature: define OBJ_ARB_CPU_PRIO_EN to let a CPU request beat the
// DMA at every arbitration point; otherwise the CPU waits for DMA completion.
module dkongjr_obj_arb #(
    parameter int DMA_LEN     = 384,
    parameter int SCAN_BANK_W = 1
) (
    input  logic                 CLK_12M,
    input  logic                 RST_4L,
    input  logic [9:0]           I_H_CNT,
    input  logic                 I_2PSL,
    dkongjr_obj_arb_if.slave     cpu,
    input  logic                 I_DMA_START,
    input  logic [15:0]          I_DMA_SRC,
    output logic                 O_SRC_RQ,
    output logic [15:0]          O_SRC_AB,
    input  logic                 I_SRC_ACK,
    input  logic [7:0]           I_SRC_D,
    output logic [9:0]           O_RAM_AB,
    output logic [7:0]           O_RAM_DI,
    output logic                 O_RAM_WE,
    output logic                 O_RAM_CS,
    input  logic [7:0]           I_RAM_DO,
    output logic                 O_DMA_BUSY,
    output logic                 O_DMA_DONE
);

`ifdef OBJ_ARB_CPU_PRIO_EN
    localparam bit CPU_PRIO = 1'b1;
`else
    localparam bit CPU_PRIO = 1'b0;
`endif

    localparam logic [9:0] LAST_CNT = 10'(DMA_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        CPU_ACC,
        CPU_RD,
        DMA_FETCH,
        DMA_WRITE
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  dma_cnt_q, dma_cnt_d;
    logic [15:0] src_base_q, src_base_d;
    logic [7:0]  byte_q, byte_d;
    logic        byte_rdy_q, byte_rdy_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        cpu_done_q, cpu_done_d;
    logic [7:0]  cpu_db_q, cpu_db_d;

    logic        scan_win;
    logic        cpu_req;
    logic        cpu_wr;
    logic        cpu_complete;
    logic [9:0]  scan_ab;
    logic [9:0]  ram_ab;
    logic [7:0]  ram_di;
    logic        ram_we;
    logic        ram_cs;
    logic        src_rq;

    assign scan_win = ~I_H_CNT[9];
    assign scan_ab  = {{SCAN_BANK_W{I_2PSL}}, I_H_CNT[9-SCAN_BANK_W:0]};
    assign cpu_wr   = ~cpu.I_CPU_WRn;
    // cpu_done blocks a second access until the CPU releases both strobes.
    assign cpu_req  = (~cpu.I_CPU_WRn | ~cpu.I_CPU_RDn) & ~cpu_done_q;

    // Next-state, DMA bookkeeping and RAM/source bus drive.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d      = state_q;
        dma_cnt_d    = dma_cnt_q;
        src_base_d   = src_base_q;
        byte_d       = byte_q;
        byte_rdy_d   = byte_rdy_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        cpu_db_d     = cpu_db_q;
        cpu_complete = 1'b0;
        ram_ab       = '0;
        ram_di       = '0;
        ram_we       = 1'b0;
        ram_cs       = 1'b0;
        src_rq       = 1'b0;

        // A start while a copy is running is ignored.
        if (I_DMA_START && !busy_q) begin
            busy_d     = 1'b1;
            src_base_d = I_DMA_SRC;
            dma_cnt_d  = '0;
            byte_rdy_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (CPU_PRIO && cpu_req && !scan_win) begin
                    state_d = CPU_ACC;
                end else if (busy_q) begin
                    // A byte held back for a CPU access is written before fetching more.
                    if (!byte_rdy_q)    state_d = DMA_FETCH;
                    else if (!scan_win) state_d = DMA_WRITE;
                end else if (cpu_req && !scan_win) begin
                    state_d = CPU_ACC;
                end
            end

            CPU_ACC: begin
                if (!cpu_req) begin
                    state_d = IDLE;
                end else if (!scan_win) begin
                    ram_ab = cpu.I_CPU_AB;
                    ram_cs = 1'b1;
                    if (cpu_wr) begin
                        ram_we       = 1'b1;
                        ram_di       = cpu.I_CPU_DB;
                        cpu_complete = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        state_d = CPU_RD;
                    end
                end
            end

            CPU_RD: begin
                // The synchronous RAM presents the addressed byte this cycle.
                cpu_db_d     = I_RAM_DO;
                cpu_complete = 1'b1;
                state_d      = IDLE;
            end

            DMA_FETCH: begin
                src_rq = 1'b1;
                if (I_SRC_ACK) begin
                    byte_d     = I_SRC_D;
                    byte_rdy_d = 1'b1;
                    state_d    = (CPU_PRIO && cpu_req) ? IDLE : DMA_WRITE;
                end
            end

            DMA_WRITE: begin
                if (!scan_win) begin
                    ram_ab     = dma_cnt_q;
                    ram_di     = byte_q;
                    ram_we     = 1'b1;
                    ram_cs     = 1'b1;
                    byte_rdy_d = 1'b0;
                    if (dma_cnt_q == LAST_CNT) begin
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        dma_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        dma_cnt_d = dma_cnt_q + 10'd1;
                        state_d   = (CPU_PRIO && cpu_req) ? IDLE : DMA_FETCH;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // The line scanner owns the RAM port whenever its window is open.
        if (scan_win) begin
            ram_ab = scan_ab;
            ram_di = '0;
            ram_we = 1'b0;
            ram_cs = 1'b1;
        end

        if (cpu.I_CPU_WRn && cpu.I_CPU_RDn) cpu_done_d = 1'b0;
        else if (cpu_complete)              cpu_done_d = 1'b1;
        else                                cpu_done_d = cpu_done_q;
    end

    // State register; reset abandons any copy in progress without a DONE pulse.
    always_ff @(posedge CLK_12M or negedge RST_4L) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!RST_4L) begin
            state_q    <= IDLE;
            dma_cnt_q  <= '0;
            src_base_q <= '0;
            byte_q     <= '0;
            byte_rdy_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cpu_done_q <= 1'b0;
            cpu_db_q   <= '0;
        end else begin
            state_q    <= state_d;
            dma_cnt_q  <= dma_cnt_d;
            src_base_q <= src_base_d;
            byte_q     <= byte_d;
            byte_rdy_q <= byte_rdy_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cpu_done_q <= cpu_done_d;
            cpu_db_q   <= cpu_db_d;
        end
    end

    assign O_RAM_AB        = ram_ab;
    assign O_RAM_DI        = ram_di;
    assign O_RAM_WE        = ram_we;
    assign O_RAM_CS        = ram_cs;
    assign O_SRC_RQ        = src_rq;
    assign O_SRC_AB        = src_rq ? (src_base_q + {6'd0, dma_cnt_q}) : 16'd0;
    assign O_DMA_BUSY      = busy_q;
    assign O_DMA_DONE      = done_q;
    assign cpu.O_CPU_DB    = cpu_db_q;
    assign cpu.O_CPU_WAITn = ~cpu_req;

endmodule

// File: doc/dkongjr_obj_arb.md
Name: dkongjr_obj_arb

Overview:
Arbiter and sequencer for the 1K x 8 object RAM feeding the sprite line engine. It shares the single RAM port between three requesters:
- the line scanner, which must own the RAM during its window;
- a CPU read/write port;
- a block-copy DMA that moves the sprite table from work RAM into object RAM once per frame.

The block drives RAM address, data and strobes, and inserts CPU wait states.

Parameters:
DMA_LEN, 384, bytes copied per DMA (1..1024); destination addresses 0..DMA_LEN-1.
SCAN_BANK_W, 1, number of bank-select bits prepended to the scan address (I_2PSL).

Ports:
CLK_12M  in  1  system clock; all state updates on rising edge.
RST_4L  in  1  asynchronous, active-low reset.
I_H_CNT  in  10  horizontal counter; I_H_CNT[9]==0 marks the scan window.
I_2PSL  in  1  scan bank select.
I_CPU_AB  in  10  CPU object RAM address.
I_CPU_DB  in  8  CPU write data.
I_CPU_WRn  in  1  CPU write strobe, active low, level.
I_CPU_RDn  in  1  CPU read strobe, active low, level.
O_CPU_DB  out  8  CPU read data, held until the next read completes.
O_CPU_WAITn  out  1  low while a CPU request is pending and not yet complete.
I_DMA_START  in  1  one-cycle pulse that starts a DMA.
I_DMA_SRC  in  16  DMA source base address, sampled at start.
O_SRC_RQ  out  1  source read request.
O_SRC_AB  out  16  source address.
I_SRC_ACK  in  1  source data valid, one cycle.
I_SRC_D  in  8  source data.
O_RAM_AB  out  10  object RAM address.
O_RAM_DI  out  8  object RAM write data.
O_RAM_WE  out  1  object RAM write enable.
O_RAM_CS  out  1  object RAM select.
I_RAM_DO  in  8  object RAM read data; synchronous RAM, 1-cycle latency.
O_DMA_BUSY  out  1  high from start until done.
O_DMA_DONE  out  1  one-cycle pulse after the last byte is written.

Behaviour:
- Reset (async, RST_4L=0): state IDLE, dma_cnt=0. All outputs 0 except O_CPU_WAITn=1. O_CPU_DB=0.
- Scan window (I_H_CNT[9]==0): combinational override.
  - O_RAM_AB={I_2PSL,I_H_CNT[8:0]}, O_RAM_CS=1, O_RAM_WE=0.
  - No CPU or DMA grant in any cycle where the window is active, including its first cycle.
- States: IDLE, CPU_ACC, CPU_RD, DMA_FETCH, DMA_WRITE.
- CPU request = (I_CPU_WRn==0 or I_CPU_RDn==0) and cpu_done==0.
  - cpu_done sets on completion and clears when both strobes are high.
  - Each strobe assertion therefore yields exactly one access.
- IDLE priority outside the window: DMA pending (busy, byte ready) > CPU request.
- CPU_ACC (1 cycle): O_RAM_AB=I_CPU_AB, CS=1. WE=1 and DI=I_CPU_DB on a write.
  - A write completes in this cycle; WAITn rises next cycle.
  - A read goes to CPU_RD, where I_RAM_DO is latched into O_CPU_DB and the access completes.
- DMA start: I_DMA_START while not busy → busy=1, src_base latched, dma_cnt=0. Start while busy is ignored.
- DMA_FETCH: O_SRC_RQ=1, O_SRC_AB=src_base+dma_cnt (16-bit wrap). Hold until I_SRC_ACK, then latch the byte.
  - The source fetch may proceed during the scan window.
- DMA_WRITE: AB=dma_cnt, DI=byte, WE=1, only outside the window; otherwise stall holding the byte.
  - Then dma_cnt++. If dma_cnt==DMA_LEN-1 before the increment → DONE pulse, busy=0, IDLE; else FETCH.
- Without the optional macro, a CPU request during DMA waits until DMA completes.
- A write is never split: the window opening during CPU_ACC/DMA_WRITE cannot occur because the grant is checked in the same cycle.
- Reset mid-DMA aborts; partial RAM contents remain. No DONE pulse is issued.

Optional Feature:
OBJ_ARB_CPU_PRIO_EN
- Defined: the CPU request beats DMA at each IDLE decision. DMA resumes after the CPU access, losing no bytes.
- Undefined: DMA > CPU as above.

Test Plan:
- Reset then release with H_CNT[9]=1, no requests → WAITn=1, CS=0, BUSY=0, CPU_DB=0.
- H_CNT=0x005, 2PSL=1 → RAM_AB=0x205, CS=1, WE=0. A simultaneous CPU write is held (WAITn=0) until H_CNT[9]=1, then 1 write.
- CPU write 0x3A to 0x10F, then read 0x10F → exactly one WE pulse; CPU_DB=0x3A two cycles after grant.
- DMA start, SRC=0x6900, ACK 1 cycle after each RQ → 384 writes, dest 0x000..0x17F, data = source; DONE one pulse; BUSY low after.
- DMA with scan window opening mid-copy → writes stall during the window, none lost or duplicated; second START while busy ignored.
- CPU read during DMA → WAITn low until DONE (macro undefined); with OBJ_ARB_CPU_PRIO_EN, completes within 3 cycles outside the window.
